// File: rtl/flit_pkg.sv
// Shared flit framing definitions, used by the link transmitter and the upstream packetizer.
package flit_pkg;

  // The flit type occupies the top FLIT_TYPE_W bits of every flit.
  localparam int FLIT_TYPE_W = 2;

  function automatic int type_lsb(input int flit_width);
    return flit_width - FLIT_TYPE_W;
  endfunction

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } link_state_e;

  function automatic logic is_start(input flit_type_e t);
    return (t == HEAD) || (t == SINGLE);
  endfunction

  function automatic logic is_end(input flit_type_e t);
    return (t == TAIL) || (t == SINGLE);
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Tracks receiver buffer credits: one spent per sent flit, one restored per return pulse.
module credit_counter #(
  parameter int credit_max   = 8,
  parameter int credit_width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spend,
  input  logic                    credit_return,
  output logic [credit_width-1:0] credits,
  output logic                    can_send,
  output logic                    credit_err
);

  localparam logic [credit_width-1:0] MAX = credit_width'(credit_max);

  assign can_send = (credits != '0);

  // A return while already full means the receiver lost count; keep the count and flag it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      credits    <= MAX;
      credit_err <= 1'b0;
    end else if (spend && !credit_return) begin
      credits <= credits - 1'b1;
    end else if (!spend && credit_return) begin
      if (credits == MAX) credit_err <= 1'b1;
      else                credits    <= credits + 1'b1;
    end
  end

endmodule

// File: rtl/flit_link_tx.sv
// Credit-based flit link transmitter: pulls framed flits from a show-ahead FIFO and drives them onto the link.
module flit_link_tx
  import flit_pkg::*;
#(
  parameter int flit_width   = 64,
  parameter int credit_max   = 8,
  parameter int credit_width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [flit_width-1:0]   fifo_out,
  input  logic                    fifo_empty,
  output logic                    fifo_consume,
  input  logic                    link_en,
  input  logic                    credit_return,
  output logic [flit_width-1:0]   link_data,
  output logic                    link_valid,
  output logic [credit_width-1:0] credits,
  output logic [15:0]             pkt_count,
  output logic                    proto_err,
  output logic                    credit_err,
  output link_state_e             state_dbg
);

  link_state_e state, state_next;
  flit_type_e  ftype;
  logic        can_send;
  logic        send;
  logic        discard;

  assign ftype     = flit_type_e'(fifo_out[flit_width-1 -: FLIT_TYPE_W]);
  assign state_dbg = state;

  credit_counter #(
    .credit_max   (credit_max),
    .credit_width (credit_width)
  ) u_credit (
    .clk           (clk),
    .rst           (rst),
    .spend         (send),
    .credit_return (credit_return),
    .credits       (credits),
    .can_send      (can_send),
    .credit_err    (credit_err)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (send) begin
      unique case (state)
        ST_IDLE: if (ftype == HEAD) state_next = ST_PKT;
        ST_PKT:  if (is_end(ftype)) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outside a packet only a start flit may go; anything else is dropped so the link stays framed.
  always_comb begin
    send    = 1'b0;
    discard = 1'b0;
    if (rst && !fifo_empty) begin
      unique case (state)
        ST_IDLE: begin
          if (is_start(ftype)) send    = link_en && can_send;
          else                 discard = 1'b1;
        end
        ST_PKT:  send = can_send;
        default: send = 1'b0;
      endcase
    end
    fifo_consume = send || discard;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      link_data  <= '0;
      link_valid <= 1'b0;
      pkt_count  <= '0;
      proto_err  <= 1'b0;
    end else begin
      link_valid <= send;
      if (send) link_data <= fifo_out;
      if (send && is_end(ftype)) pkt_count <= pkt_count + 16'd1;
      if (discard || (send && state == ST_PKT && ftype == HEAD)) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flit_link_tx.sv
// Bench for flit_link_tx: FIFO models feed two instances (8 and 2 credits); a scoreboard checks link traffic.
module tb_flit_link_tx;
  import flit_pkg::*;

  localparam int FW = 64;

  logic          clk;
  logic          rst;
  logic          link_en;
  logic [FW-1:0] fifo_out, fifo_out2;
  logic          fifo_empty, fifo_empty2;
  logic          fifo_consume, fifo_consume2;
  logic          credit_return, credit_return2;
  logic [FW-1:0] link_data, link_data2;
  logic          link_valid, link_valid2;
  logic [7:0]    credits, credits2;
  logic [15:0]   pkt_count, pkt_count2;
  logic          proto_err, proto_err2;
  logic          credit_err, credit_err2;
  link_state_e   state_dbg, state_dbg2;

  logic [FW-1:0] q1[$], q2[$];
  logic [FW-1:0] exp_q[$], exp2_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          last_c1;

  flit_link_tx #(.flit_width(FW), .credit_max(8), .credit_width(8)) u_dut (
    .clk(clk), .rst(rst), .fifo_out(fifo_out), .fifo_empty(fifo_empty),
    .fifo_consume(fifo_consume), .link_en(link_en), .credit_return(credit_return),
    .link_data(link_data), .link_valid(link_valid), .credits(credits),
    .pkt_count(pkt_count), .proto_err(proto_err), .credit_err(credit_err),
    .state_dbg(state_dbg)
  );

  flit_link_tx #(.flit_width(FW), .credit_max(2), .credit_width(8)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_out(fifo_out2), .fifo_empty(fifo_empty2),
    .fifo_consume(fifo_consume2), .link_en(link_en), .credit_return(credit_return2),
    .link_data(link_data2), .link_valid(link_valid2), .credits(credits2),
    .pkt_count(pkt_count2), .proto_err(proto_err2), .credit_err(credit_err2),
    .state_dbg(state_dbg2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input flit_type_e t);
    logic [FW-3:0] pl;
    pl = {$urandom, $urandom};
    return {t, pl};
  endfunction

  task automatic refresh();
    fifo_empty  = (q1.size() == 0);
    fifo_out    = (q1.size() != 0) ? q1[0] : '0;
    fifo_empty2 = (q2.size() == 0);
    fifo_out2   = (q2.size() != 0) ? q2[0] : '0;
  endtask

  // One clock: pop what the DUTs consumed at the edge, then score link output after it.
  task automatic tick();
    logic c1, c2;
    refresh();
    #1;
    c1 = fifo_consume;
    c2 = fifo_consume2;
    last_c1 = c1;
    @(posedge clk);
    if (c1 && q1.size() != 0) void'(q1.pop_front());
    if (c2 && q2.size() != 0) void'(q2.pop_front());
    @(negedge clk);
    credit_return  = 1'b0;
    credit_return2 = 1'b0;
    refresh();
    if (link_valid) begin
      if (exp_q.size() == 0) check("unexp_valid1", 1, 0);
      else                   check("link_data1", link_data, exp_q.pop_front());
    end
    if (link_valid2) begin
      if (exp2_q.size() == 0) check("unexp_valid2", 1, 0);
      else                    check("link_data2", link_data2, exp2_q.pop_front());
    end
  endtask

  task automatic push1(input logic [FW-1:0] f, input logic expect_sent);
    q1.push_back(f);
    if (expect_sent) exp_q.push_back(f);
  endtask

  task automatic return_credits(input int n);
    for (int i = 0; i < n; i++) begin
      credit_return = 1'b1;
      tick();
    end
  endtask

  initial begin
    logic [FW-1:0] h, b, t, s;
    int first, last, nv;
    rst = 1'b0; link_en = 1'b0; credit_return = 1'b0; credit_return2 = 1'b0;
    last_c1 = 1'b0;
    refresh();
    @(negedge clk);

    // Reset: a queued flit must not be popped while rst is low
    q1.push_back(mk(HEAD));
    refresh();
    #1;
    check("rst_consume", fifo_consume, 0);
    tick();
    tick();
    check("rst_valid", link_valid, 0);
    check("rst_data", link_data, 0);
    check("rst_credits", credits, 8);
    check("rst_credits2", credits2, 2);
    check("rst_pkt", pkt_count, 0);
    check("rst_proto", proto_err, 0);
    check("rst_cerr", credit_err, 0);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_fifo_kept", q1.size(), 1);
    q1.delete();
    rst = 1'b1;
    tick();

    // Head, body, tail back to back
    link_en = 1'b1;
    h = mk(HEAD); b = mk(BODY); t = mk(TAIL);
    push1(h, 1); push1(b, 1); push1(t, 1);
    first = -1; last = -1; nv = 0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      tick();
      if (link_valid) begin
        if (first < 0) first = i;
        last = i;
        nv++;
      end
    end
    check("t1_latency", first, 0);
    check("t1_nvalid", nv, 3);
    check("t1_consecutive", last - first + 1, 3);
    check("t1_credits", credits, 5);
    check("t1_pkt", pkt_count, 1);
    tick();
    check("t1_idle_valid", link_valid, 0);
    check("t1_hold_data", link_data, t);
    check("t1_state", state_dbg, ST_IDLE);
    return_credits(3);
    check("t1_credits_back", credits, 8);

    // Send and return in the same cycle, then return when full
    s = mk(SINGLE);
    push1(s, 1);
    credit_return = 1'b1;
    tick();
    check("t2_credits_same", credits, 8);
    check("t2_cerr_clear", credit_err, 0);
    check("t2_pkt", pkt_count, 2);
    credit_return = 1'b1;
    tick();
    check("t2_cerr_set", credit_err, 1);
    check("t2_credits_full", credits, 8);

    // Body with no packet open is dropped
    push1(mk(BODY), 0);
    tick();
    check("t3_popped", last_c1, 1);
    check("t3_valid", link_valid, 0);
    check("t3_proto", proto_err, 1);
    check("t3_credits", credits, 8);
    check("t3_fifo_empty", q1.size(), 0);

    // link_en dropped mid-packet does not split it; next start waits
    push1(mk(HEAD), 1);
    tick();
    link_en = 1'b0;
    s = mk(SINGLE);
    push1(mk(BODY), 1); push1(mk(TAIL), 1); q1.push_back(s);
    for (int i = 0; i < 4; i++) tick();
    check("t4_sent", exp_q.size(), 0);
    check("t4_waiting", q1.size(), 1);
    check("t4_valid", link_valid, 0);
    check("t4_pkt", pkt_count, 3);
    check("t4_credits", credits, 5);
    link_en = 1'b1;
    exp_q.push_back(s);
    tick();
    check("t4_go_valid", link_valid, 1);
    check("t4_go_pkt", pkt_count, 4);
    check("t4_go_credits", credits, 4);
    return_credits(4);

    // Reset for one cycle mid-packet
    push1(mk(HEAD), 1); push1(mk(BODY), 0);
    tick();
    check("t5_in_pkt", state_dbg, ST_PKT);
    rst = 1'b0;
    tick();
    check("t5_valid", link_valid, 0);
    check("t5_data", link_data, 0);
    check("t5_credits", credits, 8);
    check("t5_pkt", pkt_count, 0);
    check("t5_proto", proto_err, 0);
    check("t5_cerr", credit_err, 0);
    check("t5_state", state_dbg, ST_IDLE);
    check("t5_body_kept", q1.size(), 1);
    rst = 1'b1;
    tick();
    check("t5_discard_valid", link_valid, 0);
    check("t5_discard_proto", proto_err, 1);
    check("t5_discard_pop", q1.size(), 0);

    // Two-credit instance: four-flit packet stalls after two flits
    begin
      logic [FW-1:0] f[4];
      f[0] = mk(HEAD); f[1] = mk(BODY); f[2] = mk(BODY); f[3] = mk(TAIL);
      for (int i = 0; i < 4; i++) begin
        q2.push_back(f[i]);
        exp2_q.push_back(f[i]);
      end
    end
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (link_valid2) nv++;
    end
    check("t6_nvalid", nv, 2);
    check("t6_credits0", credits2, 0);
    check("t6_left", q2.size(), 2);
    credit_return2 = 1'b1;
    tick();
    check("t6_ret_valid", link_valid2, 0);
    check("t6_ret_credits", credits2, 1);
    tick();
    check("t6_flit3_valid", link_valid2, 1);
    check("t6_flit3_credits", credits2, 0);
    credit_return2 = 1'b1;
    tick();
    tick();
    check("t6_pkt", pkt_count2, 1);
    check("t6_exp_empty", exp2_q.size(), 0);

    check("final_exp_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
